// File: rtl/calc_pkg.sv
// Shared types and constants for the parametrised two-key binary calculator.
package calc_pkg;

    // Pending arithmetic operation
    typedef enum logic [1:0] {
        NONE = 2'd0,
        ADD  = 2'd1,
        SUB  = 2'd2
    } op_t;

    // Calculator control states
    typedef enum logic [2:0] {
        A_ENTRY = 3'd0,
        OP_WAIT = 3'd1,
        B_ENTRY = 3'd2,
        RESULT  = 3'd3,
        ERR     = 3'd4
    } state_t;

    // Segment patterns {dp,a,b,c,d,e,f,g}, active high
    localparam logic [7:0] SEG_ZERO  = 8'b0111_1110;
    localparam logic [7:0] SEG_ONE   = 8'b0011_0000;
    localparam logic [7:0] SEG_E     = 8'b0100_1111;
    localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

    // Key indices; a higher index wins when presses coincide
    localparam int KEY_NUM0  = 0;
    localparam int KEY_NUM1  = 1;
    localparam int KEY_MINUS = 2;
    localparam int KEY_PLUS  = 3;
    localparam int KEY_EQUAL = 4;
    localparam int NUM_KEYS  = 5;

    // Digits are entered MSB-first, so after cnt digits bits [width-1 : width-cnt] are valid
    function automatic logic digit_entered(input int idx, input int cnt, input int width);
        return idx >= (width - cnt);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: two-flop synchroniser followed by a stability counter.
// Emits a single-cycle press pulse on the DEB_CYCLES-th consecutive high cycle;
// the key must drop low before another pulse can be produced.
module key_debounce #(
    parameter int DEB_CYCLES = 8000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    // Synchronise, count the stable-high run (saturating), pulse exactly once per run
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            if (!sync2_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CW'(DEB_CYCLES)) begin
                cnt_q <= cnt_q + CW'(1);
            end
            press_q <= sync2_q && (cnt_q == CW'(DEB_CYCLES - 1));
        end
    end

    assign press = press_q;

endmodule

// File: rtl/calc_core_param.sv
// Parametrised binary calculator: W-bit operands entered MSB-first with two
// debounced keys, added or subtracted, shown on a 2*W digit multiplexed display.
// Build option: define CALC_CHAIN_EN to let plus/minus in RESULT chain the
// result into a new calculation as operand a.
module calc_core_param
    import calc_pkg::*;
#(
    parameter int W          = 4,
    parameter int DEB_CYCLES = 8000000,
    parameter int SCAN_DIV   = 8192
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           num_0,
    input  logic           num_1,
    input  logic           plus,
    input  logic           minus,
    input  logic           equal,
    output logic [7:0]     seg,
    output logic [2*W-1:0] digit_en,
    output logic           error,
    output logic           busy
);

    localparam int CW = $clog2(W + 1);
    localparam int PW = $clog2(2 * W);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [W-1:0]   MSB_MASK  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]   LSB_ONE   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] DIGIT_ONE = {{(2*W-1){1'b0}}, 1'b1};

    // ---------------- key conditioning ----------------
    logic [NUM_KEYS-1:0] keys_raw;
    logic [NUM_KEYS-1:0] press_w;
    logic [NUM_KEYS-1:0] key_sel;

    assign keys_raw[KEY_NUM0]  = num_0;
    assign keys_raw[KEY_NUM1]  = num_1;
    assign keys_raw[KEY_MINUS] = minus;
    assign keys_raw[KEY_PLUS]  = plus;
    assign keys_raw[KEY_EQUAL] = equal;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk    (clk),
                .reset  (reset),
                .key_in (keys_raw[gi]),
                .press  (press_w[gi])
            );
        end
    endgenerate

    // Keep only the highest-priority press when several coincide
    always_comb begin
        key_sel = '0;
        if (press_w[KEY_EQUAL])      key_sel[KEY_EQUAL] = 1'b1;
        else if (press_w[KEY_PLUS])  key_sel[KEY_PLUS]  = 1'b1;
        else if (press_w[KEY_MINUS]) key_sel[KEY_MINUS] = 1'b1;
        else if (press_w[KEY_NUM1])  key_sel[KEY_NUM1]  = 1'b1;
        else if (press_w[KEY_NUM0])  key_sel[KEY_NUM0]  = 1'b1;
    end

    logic num_press;
    logic num_bit;
    assign num_press = key_sel[KEY_NUM0] | key_sel[KEY_NUM1];
    assign num_bit   = key_sel[KEY_NUM1];

    // ---------------- calculator state ----------------
    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  entry_mask;
    logic [W:0]    sum;

    assign entry_mask = MSB_MASK >> cnt_q;
    assign sum        = {1'b0, a_q} + {1'b0, b_q};

    // Next-state logic for operand entry, operator selection and evaluation
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        case (state_q)
            A_ENTRY: begin
                if (num_press) begin
                    a_d = num_bit ? (a_q | entry_mask) : (a_q & ~entry_mask);
                    if (cnt_q == CW'(W - 1)) begin
                        cnt_d   = '0;
                        state_d = OP_WAIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            OP_WAIT: begin
                if (key_sel[KEY_PLUS]) begin
                    op_d    = ADD;
                    state_d = B_ENTRY;
                end else if (key_sel[KEY_MINUS]) begin
                    op_d    = SUB;
                    state_d = B_ENTRY;
                end
            end
            B_ENTRY: begin
                if (num_press) begin
                    // extra digits after b is complete are dropped
                    if (cnt_q != CW'(W)) begin
                        b_d   = num_bit ? (b_q | entry_mask) : (b_q & ~entry_mask);
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (key_sel[KEY_PLUS]) begin
                    op_d = ADD;
                end else if (key_sel[KEY_MINUS]) begin
                    op_d = SUB;
                end else if (key_sel[KEY_EQUAL] && (cnt_q == CW'(W))) begin
                    if (op_q == SUB) begin
                        if (a_q < b_q) begin
                            state_d = ERR;
                        end else begin
                            r_d     = a_q - b_q;
                            state_d = RESULT;
                        end
                    end else begin
                        if (sum[W]) begin
                            state_d = ERR;
                        end else begin
                            r_d     = sum[W-1:0];
                            state_d = RESULT;
                        end
                    end
                end
            end
            RESULT, ERR: begin
                if (num_press) begin
                    // the pressed digit becomes the first digit of a new operand a
                    a_d     = num_bit ? MSB_MASK : '0;
                    b_d     = '0;
                    op_d    = NONE;
                    cnt_d   = CW'(1);
                    state_d = A_ENTRY;
                end
`ifdef CALC_CHAIN_EN
                else if ((state_q == RESULT) && (key_sel[KEY_PLUS] || key_sel[KEY_MINUS])) begin
                    a_d     = r_q;
                    b_d     = '0;
                    cnt_d   = '0;
                    op_d    = key_sel[KEY_PLUS] ? ADD : SUB;
                    state_d = B_ENTRY;
                end
`endif
            end
            default: begin
                state_d = A_ENTRY;
            end
        endcase
    end

    // Calculator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= A_ENTRY;
            op_q    <= NONE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    assign error = (state_q == ERR);
    assign busy  = ((state_q == A_ENTRY) || (state_q == B_ENTRY)) &&
                   (cnt_q != '0) && (cnt_q != CW'(W));

    // ---------------- display ----------------
    logic [DW-1:0]  div_q;
    logic [PW-1:0]  pos_q;
    logic [7:0]     seg_q, seg_d;
    logic [2*W-1:0] digit_en_q, digit_en_d;

    // Scan position advances one digit every SCAN_DIV cycles, LSB to MSB, wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            pos_q <= '0;
        end else if (div_q == DW'(SCAN_DIV - 1)) begin
            div_q <= '0;
            pos_q <= (pos_q == PW'(2 * W - 1)) ? '0 : pos_q + PW'(1);
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    logic          left_half;
    logic [PW-1:0] idx;
    logic [W-1:0]  shown;
    logic          vis;
    logic          bitv;
    logic          dp;

    // Pattern and enable for the digit currently being scanned
    always_comb begin
        left_half = (pos_q >= PW'(W));
        idx       = left_half ? (pos_q - PW'(W)) : pos_q;
        if (left_half) begin
            shown = (state_q == RESULT) ? r_q : a_q;
            vis   = (state_q != A_ENTRY) || digit_entered(int'(idx), int'(cnt_q), W);
        end else begin
            shown = b_q;
            vis   = (state_q == B_ENTRY) && digit_entered(int'(idx), int'(cnt_q), W);
        end
        bitv = |(shown & (LSB_ONE << idx));
        dp   = ((op_q == ADD) && (pos_q == PW'(W))) || ((op_q == SUB) && (pos_q == '0));
        seg_d      = SEG_BLANK;
        digit_en_d = '0;
        if (state_q == ERR) begin
            seg_d      = SEG_E;
            digit_en_d = DIGIT_ONE << pos_q;
        end else if (vis) begin
            seg_d      = (bitv ? SEG_ONE : SEG_ZERO) | {dp, 7'b000_0000};
            digit_en_d = DIGIT_ONE << pos_q;
        end
    end

    // Segment and enable outputs are registered together so they switch on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q      <= SEG_BLANK;
            digit_en_q <= '0;
        end else begin
            seg_q      <= seg_d;
            digit_en_q <= digit_en_d;
        end
    end

    assign seg      = seg_q;
    assign digit_en = digit_en_q;

endmodule

// File: tb/tb_calc_core_param.sv
// Scoreboard bench for calc_core_param (W=4, DEB_CYCLES=4, SCAN_DIV=2).
// Stimulus pushes the hand-computed expected display frame; a monitor captures
// one full scan rotation from the pins and compares it.
module tb_calc_core_param;

    localparam int W    = 4;
    localparam int DEB  = 4;
    localparam int SCAN = 2;

    localparam logic [4:0] K0 = 5'b00001;
    localparam logic [4:0] K1 = 5'b00010;
    localparam logic [4:0] KM = 5'b00100;
    localparam logic [4:0] KP = 5'b01000;
    localparam logic [4:0] KE = 5'b10000;

    logic       clk = 1'b0;
    logic       reset;
    logic       num_0, num_1, plus, minus, equal;
    logic [7:0] seg;
    logic [7:0] digit_en;
    logic       error, busy;

    always #5 clk = ~clk;

    calc_core_param #(.W(W), .DEB_CYCLES(DEB), .SCAN_DIV(SCAN)) dut (
        .clk      (clk),
        .reset    (reset),
        .num_0    (num_0),
        .num_1    (num_1),
        .plus     (plus),
        .minus    (minus),
        .equal    (equal),
        .seg      (seg),
        .digit_en (digit_en),
        .error    (error),
        .busy     (busy)
    );

    typedef struct {
        logic [71:0] frame;
        logic        err;
        logic        bsy;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_busy = 1'b0;

    task automatic check_val(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Frame: 9 bits per position {visible, seg}; chars '0','1','E', '-' = blank
    function automatic logic [71:0] mk_frame(input string left, input string right, input int dp_pos);
        logic [71:0] f;
        logic [8:0]  e;
        string       s;
        int          p;
        f = '0;
        s = {left, right};
        for (int i = 0; i < 8; i++) begin
            p = 7 - i;
            case (s[i])
                "0":     e = {1'b1, 8'b0111_1110};
                "1":     e = {1'b1, 8'b0011_0000};
                "E":     e = {1'b1, 8'b0100_1111};
                default: e = 9'd0;
            endcase
            if (e[8] && (p == dp_pos)) e[7] = 1'b1;
            f[p*9 +: 9] = e;
        end
        return f;
    endfunction

    task automatic expect_frame(input string name, input string left, input string right,
                                input int dp_pos, input logic err, input logic bsy);
        exp_t e;
        e.frame = mk_frame(left, right, dp_pos);
        e.err   = err;
        e.bsy   = bsy;
        e.name  = name;
        sb_q.push_back(e);
        for (int i = 0; i < 200 && (sb_q.size() != 0 || mon_busy); i++) @(negedge clk);
        if (sb_q.size() != 0 || mon_busy) begin
            n_checks++;
            $display("FAIL %s: monitor did not complete within 200 cycles", name);
        end
    endtask

    task automatic drive_keys(input logic [4:0] k);
        {equal, plus, minus, num_1, num_0} = k;
    endtask

    task automatic tap(input logic [4:0] k, input int hold);
        @(negedge clk);
        drive_keys(k);
        repeat (hold) @(negedge clk);
        drive_keys(5'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic enter(input string bits);
        for (int i = 0; i < bits.len(); i++) tap((bits[i] == "1") ? K1 : K0, 8);
    endtask

    // Monitor: capture one full scan rotation and compare against the scoreboard head
    exp_t        mon_cur;
    logic [71:0] mon_obs;
    bit          mon_bad;
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                mon_busy = 1'b1;
                mon_cur  = sb_q.pop_front();
                mon_obs  = '0;
                mon_bad  = 1'b0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (digit_en != 8'd0) begin
                        if ($onehot(digit_en)) begin
                            for (int p = 0; p < 8; p++)
                                if (digit_en[p]) mon_obs[p*9 +: 9] = {1'b1, seg};
                        end else begin
                            mon_bad = 1'b1;
                        end
                    end else if (seg != 8'd0) begin
                        mon_bad = 1'b1;
                    end
                end
                check_val({mon_cur.name, ".frame"}, mon_obs, mon_cur.frame);
                check_val({mon_cur.name, ".error"}, 72'(error), 72'(mon_cur.err));
                check_val({mon_cur.name, ".busy"}, 72'(busy), 72'(mon_cur.bsy));
                check_val({mon_cur.name, ".blank"}, 72'(mon_bad), 72'(0));
                $display("frame %s checked", mon_cur.name);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive_keys(5'b0);
        repeat (3) @(negedge clk);
        check_val("rst.seg", 72'(seg), 72'(0));
        check_val("rst.digit_en", 72'(digit_en), 72'(0));
        check_val("rst.error", 72'(error), 72'(0));
        check_val("rst.busy", 72'(busy), 72'(0));
        reset = 1'b0;
        expect_frame("idle", "----", "----", -1, 1'b0, 1'b0);

        // 0110 + 0011 = 1001
        enter("0110");
        expect_frame("t1_a", "0110", "----", -1, 1'b0, 1'b0);
        tap(KP, 8);
        expect_frame("t1_op", "0110", "----", 4, 1'b0, 1'b0);
        enter("00");
        expect_frame("t1_b2", "0110", "00--", 4, 1'b0, 1'b1);
        tap(KE, 8);
        expect_frame("t1_early_eq", "0110", "00--", 4, 1'b0, 1'b1);
        enter("11");
        expect_frame("t1_b", "0110", "0011", 4, 1'b0, 1'b0);
        tap(KE, 8);
        expect_frame("t1_res", "1001", "----", 4, 1'b0, 1'b0);

        // 1000 + 1000 overflows -> ERR, then a digit restarts entry
        tap(K1, 8);
        expect_frame("t2_restart", "1---", "----", -1, 1'b0, 1'b1);
        enter("000");
        expect_frame("t2_a", "1000", "----", -1, 1'b0, 1'b0);
        tap(KP, 8);
        enter("1000");
        tap(KE, 8);
        expect_frame("t2_err", "EEEE", "EEEE", -1, 1'b1, 1'b0);
        tap(K1, 8);
        expect_frame("t2_exit", "1---", "----", -1, 1'b0, 1'b1);
        tap(K0, 8);
        expect_frame("t2_two", "10--", "----", -1, 1'b0, 1'b1);

        // reset in the middle of entry
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_rst.seg", 72'(seg), 72'(0));
        check_val("mid_rst.digit_en", 72'(digit_en), 72'(0));
        check_val("mid_rst.busy", 72'(busy), 72'(0));
        reset = 1'b0;
        expect_frame("mid_rst", "----", "----", -1, 1'b0, 1'b0);

        // debounce: 3-cycle glitch ignored, 40-cycle hold gives one digit
        tap(K1, 3);
        expect_frame("glitch", "----", "----", -1, 1'b0, 1'b0);
        tap(K1, 40);
        expect_frame("long_hold", "1---", "----", -1, 1'b0, 1'b1);
        enter("011");
        expect_frame("t3_a", "1011", "----", -1, 1'b0, 1'b0);
        tap(KM, 8);
        expect_frame("t3_sub", "1011", "----", -1, 1'b0, 1'b0);
        tap(KP | K1, 8);
        expect_frame("prio", "1011", "----", 4, 1'b0, 1'b0);
        enter("0001");
        tap(KE, 8);
        expect_frame("t3_res", "1100", "----", 4, 1'b0, 1'b0);

        // 0010 - 0100 -> ERR
        enter("0010");
        tap(KM, 8);
        enter("0100");
        expect_frame("t4_b", "0010", "0100", 0, 1'b0, 1'b0);
        tap(KE, 8);
        expect_frame("t4_err", "EEEE", "EEEE", -1, 1'b1, 1'b0);

        // 0100 - 0010 = 0010
        enter("0100");
        tap(KM, 8);
        enter("0010");
        tap(KE, 8);
        expect_frame("t5_res", "0010", "----", -1, 1'b0, 1'b0);

        // 0011 + 0001 = 0100, then plus in RESULT
        enter("0011");
        tap(KP, 8);
        enter("0001");
        tap(KE, 8);
        expect_frame("t6_res", "0100", "----", 4, 1'b0, 1'b0);
        tap(KP, 8);
`ifdef CALC_CHAIN_EN
        expect_frame("chain_op", "0100", "----", 4, 1'b0, 1'b0);
        enter("0001");
        expect_frame("chain_b", "0100", "0001", 4, 1'b0, 1'b0);
        tap(KE, 8);
        expect_frame("chain_res", "0101", "----", 4, 1'b0, 1'b0);
`else
        expect_frame("plus_in_res", "0100", "----", 4, 1'b0, 1'b0);
        tap(K1, 8);
        expect_frame("after_plus", "1---", "----", -1, 1'b0, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_core_param.md
Name: calc_core_param

Overview:
- Parametrised successor of the two-key binary calculator. Operands of W bits are entered MSB-first with debounced num_0/num_1 keys, then added or subtracted.
- Operands and result are shown one binary digit per seven-segment position on a time-multiplexed display of 2*W digits.
- Sits between the board push-buttons and the segment/digit-enable pins. It is the single top-level functional block.

Parameters:
- W, 4, operand width in bits; display has 2*W digit positions (W >= 2).
- DEB_CYCLES, 8000000, cycles a key must be stably high before it registers as one press.
- SCAN_DIV, 8192, cycles each digit position stays enabled during scanning.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- num_0  in  1  key: enter bit 0
- num_1  in  1  key: enter bit 1
- plus  in  1  key: select add
- minus  in  1  key: select subtract
- equal  in  1  key: evaluate
- seg  out  8  segment pattern {dp,a,b,c,d,e,f,g}, active high
- digit_en  out  2*W  one-hot digit enable; bit 2W-1 is leftmost
- error  out  1  high while in ERR state
- busy  out  1  high while an operand is only partially entered

Behaviour:
- Reset (synchronous, active-high, sampled on the clk edge) clears all registers.
  - Outputs after reset: seg=0, digit_en=0, error=0, busy=0.
  - State after reset: A_ENTRY, cnt=0, op=NONE.
- Key handling: each key passes through 2-FF sync, then a stability counter.
  - One-cycle press pulse fires when the key has been high for exactly DEB_CYCLES consecutive cycles.
  - The key must go low before it can pulse again.
  - Reset mid-count discards the pending press.
  - Simultaneous pulses take priority equal > plus > minus > num_1 > num_0; the others are dropped.
- FSM states: A_ENTRY, OP_WAIT, B_ENTRY, RESULT, ERR.
  - A_ENTRY: a num pulse writes a[W-1-cnt] and increments cnt. When cnt reaches W, go to OP_WAIT with cnt=0. plus/minus/equal are ignored.
  - OP_WAIT: plus sets op=ADD, minus sets op=SUB, then go to B_ENTRY. num and equal are ignored.
  - B_ENTRY: a num pulse writes b[W-1-cnt]. plus/minus may change op. equal is accepted only when cnt==W.
  - On equal:
    - ADD: r = a+b computed W+1 wide. If bit W is set, go to ERR; else go to RESULT.
    - SUB: if a<b, go to ERR; else r = a-b, go to RESULT.
  - RESULT/ERR: any num pulse clears a, b, cnt and op and goes to A_ENTRY, loading that bit as a[W-1]. All other keys are ignored.
- busy = 1 when (A_ENTRY or B_ENTRY) and 0<cnt<W.
- Display:
  - Scan counter advances digit_en one position every SCAN_DIV cycles, rotating from LSB to MSB and wrapping.
  - Left W digits show a (r in RESULT). Right W digits show b (blank in RESULT).
  - Positions not yet entered are blank: seg=0 and their digit_en bit forced 0.
  - Patterns: 0 -> 0111_1110, 1 -> 0011_0000, E -> 0100_1111.
  - dp is set on the LSB digit of the left half when op=ADD, and on the LSB digit of the right half when op=SUB.
  - In ERR every position shows E, with dp=0.
  - seg and digit_en are registered and change on the same edge.

Optional Feature:
- CALC_CHAIN_EN
  - Defined: in RESULT, a plus/minus pulse loads a<=r, b<=0, cnt<=0, sets op, and goes to B_ENTRY, so calculations can be chained.
  - Undefined: plus/minus are ignored in RESULT, as stated above.

Decomposition:
- Package calc_pkg:
  - op_t enum {NONE, ADD, SUB}
  - state_t enum
  - SEG_ZERO, SEG_ONE, SEG_E, SEG_BLANK constants
  - key priority index constants
- Sub-module key_debounce (parameter DEB_CYCLES; ports clk, reset, key_in, press) is instantiated five times.

Test Plan (W=4, DEB_CYCLES=4, SCAN_DIV=2):
- Enter 0,1,1,0 / plus / 0,0,1,1 / equal -> RESULT, r=1001; left digits scan 1,0,0,1, right half blank, error=0.
- Enter 1,0,0,0 / plus / 1,0,0,0 / equal -> ERR; all digit_en positions show 0100_1111, error=1; then num_1 -> A_ENTRY with a[3]=1, error=0.
- Enter 0,0,1,0 / minus / 0,1,0,0 / equal -> ERR (2<4). Repeat with 0100 - 0010 -> r=0010.
- Key glitch of 3 cycles -> no press. Key held 40 cycles -> exactly one press. plus and num_1 asserted on the same cycle -> only plus registers.
- After two digits of a (busy=1), assert reset for 1 cycle -> next edge seg=0, digit_en=0, busy=0, cnt=0.
- With CALC_CHAIN_EN: 0011+0001= then plus, 0001, equal -> r=0101. Without the macro, plus in RESULT leaves r=0100 displayed.
